// File: rtl/data_memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_responder_pkg
//   Shared definitions for the data-memory responder: FSM state encoding
//   (the same values control and ALU use), bus/byte constants and the
//   address range helper.
// ---------------------------------------------------------------------------
package data_memory_responder_pkg;

  // FSM state encoding shared with the rest of the core.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int ADDR_BUS_WIDTH     = 32;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int BYTE_WIDTH         = 8;
  // Wait counter is wide enough for the largest legal LATENCY (15).
  localparam int CNT_WIDTH          = 4;

  // True when any address bit at or above addr_width is set. The upper bits
  // are checked rather than dropped, so nothing ever wraps into the array.
  function automatic logic addr_out_of_range(input logic [ADDR_BUS_WIDTH-1:0] addr,
                                             input int addr_width);
    logic oor;
    oor = 1'b0;
    for (int i = 0; i < ADDR_BUS_WIDTH; i++) begin
      if ((i >= addr_width) && addr[i]) begin
        oor = 1'b1;
      end
    end
    return oor;
  endfunction

endpackage

// File: rtl/data_memory_responder_dmem_array.sv
// ---------------------------------------------------------------------------
// data_memory_responder_dmem_array
//   Byte-enabled word storage. One lane array per byte so each lane maps onto
//   its own RAM column with an independent write enable. Synchronous write,
//   combinational read, contents are never reset.
// Ports
//   clk    in   write clock, rising edge
//   we     in   write strobe for this edge
//   addr   in   word address, shared by read and write
//   wdata  in   store data
//   be     in   per-byte write mask, bit i -> wdata[8i+7:8i]
//   rdata  out  word at addr (combinational)
// ---------------------------------------------------------------------------
module data_memory_responder_dmem_array
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int BYTE_COUNT = DATA_WIDTH / BYTE_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < BYTE_COUNT; gi++) begin : g_lane
      logic [BYTE_WIDTH-1:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end

      assign rdata[gi*BYTE_WIDTH +: BYTE_WIDTH] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//   Load/store responder for the core's data memory. A request seen in IDLE
//   is latched, waits LATENCY cycles, then completes with a one-cycle
//   mem_ready pulse (qualified by mem_error). While busy, new requests are
//   ignored; there is no queueing.
// Timing (accept at edge N)
//   - array commit / load sample on edge N+LATENCY (the edge entering RESP)
//   - mem_ready, mem_error high in the cycle after edge N+LATENCY+1
//   - next request can be accepted at edge N+LATENCY+2
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   mem_read    in   load request
//   mem_write   in   store request
//   address     in   32-bit word address (upper bits must be zero)
//   write_data  in   store data
//   byte_enable in   per-byte store mask (ignored for loads)
//   read_data   out  load data, valid while mem_ready=1, held until next load
//   mem_ready   out  one-cycle completion pulse
//   mem_busy    out  request in flight (WAIT/RESP)
//   mem_error   out  qualifies mem_ready: request faulted
// ---------------------------------------------------------------------------
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int LATENCY    = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mem_read,
  input  logic                             mem_write,
  input  logic [ADDR_BUS_WIDTH-1:0]        address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_enable,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             mem_ready,
  output logic                             mem_busy,
  output logic                             mem_error
);

  localparam int BYTE_COUNT = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
    (LATENCY == 0) ? '0 : CNT_WIDTH'(LATENCY - 1);

  state_e                  state_reg;
  logic [CNT_WIDTH-1:0]    cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [BYTE_COUNT-1:0]   be_reg;
  logic                    is_store_reg;
  logic                    fault_reg;
  logic [DATA_WIDTH-1:0]   read_data_reg;
  logic                    ready_reg;
  logic                    busy_reg;
  logic                    error_reg;

  logic                    req;
  logic                    accept;
  logic                    req_is_store;
  logic                    req_fault;
  logic                    bypass;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [DATA_WIDTH-1:0]   eff_wdata;
  logic [BYTE_COUNT-1:0]   eff_be;
  logic                    eff_store;
  logic                    eff_fault;
  logic                    array_we;
  logic [DATA_WIDTH-1:0]   array_rdata;

  // Fault conditions are decided once, from the inputs at accept time.
  assign req          = mem_read | mem_write;
  assign accept       = (state_reg == S_IDLE) && req;
  assign req_is_store = mem_write & ~mem_read;
  assign req_fault    = addr_out_of_range(address, ADDR_WIDTH)
                      | (mem_read & mem_write)
                      | (req_is_store & ~(|byte_enable));

  // With LATENCY=0 the accept edge is also the commit edge, so the array is
  // driven straight from the request inputs instead of the latched copy.
  assign bypass = accept && (LATENCY == 0);
  assign commit = bypass || ((state_reg == S_WAIT) && (cnt_reg == '0));

  assign eff_addr  = bypass ? address[ADDR_WIDTH-1:0] : addr_reg;
  assign eff_wdata = bypass ? write_data              : wdata_reg;
  assign eff_be    = bypass ? byte_enable             : be_reg;
  assign eff_store = bypass ? req_is_store            : is_store_reg;
  assign eff_fault = bypass ? req_fault               : fault_reg;

  // Gating with rst_n keeps a store from landing when reset falls on its
  // commit edge.
  assign array_we = commit & eff_store & ~eff_fault & rst_n;

  data_memory_responder_dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dmem_array (
    .clk   (clk),
    .we    (array_we),
    .addr  (eff_addr),
    .wdata (eff_wdata),
    .be    (eff_be),
    .rdata (array_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      is_store_reg  <= 1'b0;
      fault_reg     <= 1'b0;
      read_data_reg <= '0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      error_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (req) begin
            addr_reg     <= address[ADDR_WIDTH-1:0];
            wdata_reg    <= write_data;
            be_reg       <= byte_enable;
            is_store_reg <= req_is_store;
            fault_reg    <= req_fault;
            busy_reg     <= 1'b1;
            if (LATENCY == 0) begin
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_WAIT;
              cnt_reg   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_RESP: begin
          // The pulse is registered here so it lands in the first IDLE cycle.
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
          error_reg <= fault_reg;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      // Load data is captured on the commit edge and held until the next
      // load/fault response; a good store leaves it untouched.
      if (commit) begin
        if (eff_fault) begin
          read_data_reg <= '0;
        end else if (!eff_store) begin
          read_data_reg <= array_rdata;
        end
      end
    end
  end

  assign read_data = read_data_reg;
  assign mem_ready = ready_reg;
  assign mem_busy  = busy_reg;
  assign mem_error = error_reg;

endmodule
